// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Function : Three-requester write-back arbiter. Each requester has a 2-deep
//            result queue, and one result per cycle goes round-robin onto the CDB.
// Revision : 1.0
// ============================================================================
module wb_arbiter #(
  parameter int ROB_BIT    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic [2:0]           req_valid,
  input  logic [3*ROB_BIT-1:0] req_rob_entry,
  input  logic [95:0]          req_value,
  output logic [2:0]           req_ready,
  output logic                 cdb_valid,
  output logic [ROB_BIT-1:0]   cdb_rob_entry,
  output logic [31:0]          cdb_value,
  output logic [1:0]           cdb_src
);

  localparam logic [1:0] c_FULL = 2'(FIFO_DEPTH);

  logic [ROB_BIT-1:0] r_q_entry [3][2];
  logic [31:0]        r_q_value [3][2];
  logic [2:0]         r_wptr;
  logic [2:0]         r_rptr;
  logic [1:0]         r_cnt [3];
  logic [1:0]         r_last_grant;

  logic [2:0]         w_push;
  logic [2:0]         w_pop;
  logic               w_grant_vld;
  logic [1:0]         w_grant_idx;
  logic [ROB_BIT-1:0] w_head_entry;
  logic [31:0]        w_head_value;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_grant_vld  = 1'b0;
    w_grant_idx  = 2'd0;
    w_head_entry = '0;
    w_head_value = '0;
    for (int k = 0; k < 3; k++) begin
      int cand;
      cand = (int'(r_last_grant) + 1 + k) % 3;
      if (!w_grant_vld && (r_cnt[cand] != 2'd0)) begin
        w_grant_vld  = 1'b1;
        w_grant_idx  = 2'(cand);
        w_head_entry = r_q_entry[cand][r_rptr[cand]];
        w_head_value = r_q_value[cand][r_rptr[cand]];
      end
    end
  end

  always_comb begin
    w_pop = 3'b000;
    if (w_grant_vld) w_pop[w_grant_idx] = 1'b1;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_queue
      // Ready looks only at registered occupancy; a full queue never bypasses.
      assign req_ready[gi] = (r_cnt[gi] != c_FULL) && !flush_in;
      assign w_push[gi]    = rdy_in && !flush_in && req_valid[gi] && req_ready[gi];

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_cnt[gi]  <= 2'd0;
          r_wptr[gi] <= 1'b0;
          r_rptr[gi] <= 1'b0;
        end else if (rdy_in) begin
          if (flush_in) begin
            r_cnt[gi]  <= 2'd0;
            r_wptr[gi] <= 1'b0;
            r_rptr[gi] <= 1'b0;
          end else begin
            if (w_push[gi]) r_wptr[gi] <= ~r_wptr[gi];
            if (w_pop[gi])  r_rptr[gi] <= ~r_rptr[gi];
            case ({w_push[gi], w_pop[gi]})
              2'b10:   r_cnt[gi] <= r_cnt[gi] + 2'd1;
              2'b01:   r_cnt[gi] <= r_cnt[gi] - 2'd1;
              default: r_cnt[gi] <= r_cnt[gi];
            endcase
          end
        end
      end

      always_ff @(posedge clk_in) begin
        if (w_push[gi]) begin
          r_q_entry[gi][r_wptr[gi]] <= req_rob_entry[gi*ROB_BIT +: ROB_BIT];
          r_q_value[gi][r_wptr[gi]] <= req_value[gi*32 +: 32];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_last_grant  <= 2'd2;
      cdb_valid     <= 1'b0;
      cdb_rob_entry <= '0;
      cdb_value     <= '0;
      cdb_src       <= 2'd0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_last_grant  <= 2'd2;
        cdb_valid     <= 1'b0;
        cdb_rob_entry <= '0;
        cdb_value     <= '0;
        cdb_src       <= 2'd0;
      end else if (w_grant_vld) begin
        r_last_grant  <= w_grant_idx;
        cdb_valid     <= 1'b1;
        cdb_rob_entry <= w_head_entry;
        cdb_value     <= w_head_value;
        cdb_src       <= w_grant_idx;
      end else begin
        cdb_valid     <= 1'b0;
        cdb_rob_entry <= '0;
        cdb_value     <= '0;
        cdb_src       <= 2'd0;
      end
    end
  end

endmodule
`default_nettype wire
